// File: rtl/apb3_master.sv
// APB3 master: turns a cmd/rsp handshake into a single APB3 transfer, with an optional
// wait-state timeout so a slave that never raises PREADY cannot hang the bus.
module apb3_master #(
   parameter int unsigned ADDR_WIDTH     = 12,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  io_systemClk,
   input  logic                  io_asyncReset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic                  rsp_timeout,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic                  PREADY,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PSLVERROR
);

   localparam logic [7:0] TimeoutLimit = 8'(TIMEOUT_CYCLES);
   localparam bit         TimeoutEn    = (TIMEOUT_CYCLES != 0);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_t;

   state_t                  state_q, state_d;
   logic [7:0]              wait_cnt_q, wait_cnt_d;
   logic                    capture, timeout_hit;
   logic [ADDR_WIDTH-1:0]   paddr_q;
   logic [DATA_WIDTH-1:0]   pwdata_q;
   logic                    pwrite_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;
   logic                    rsp_error_q, rsp_timeout_q;

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cmd_valid) state_d = StSetup;
         end
         StSetup: begin
            state_d    = StAccess;
            wait_cnt_d = 8'd0;
         end
         StAccess: begin
            // PREADY takes priority over a timeout reached in the same cycle
            if (PREADY) begin
               state_d = StResp;
               capture = 1'b1;
            end else if (TimeoutEn && (wait_cnt_q == TimeoutLimit)) begin
               state_d     = StResp;
               timeout_hit = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge io_systemClk or posedge io_asyncReset) begin
      if (io_asyncReset) begin
         state_q       <= StIdle;
         wait_cnt_q    <= 8'd0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pwrite_q      <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_error_q   <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (state_q == StIdle && cmd_valid) begin
            paddr_q  <= cmd_addr;
            pwdata_q <= cmd_wdata;
            pwrite_q <= cmd_write;
         end
         if (capture) begin
            rsp_rdata_q   <= (!pwrite_q && !PSLVERROR) ? PRDATA : '0;
            rsp_error_q   <= PSLVERROR;
            rsp_timeout_q <= 1'b0;
         end else if (timeout_hit) begin
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
         end
      end
   end

   assign cmd_ready   = (state_q == StIdle);
   assign busy        = (state_q != StIdle);
   assign PSEL        = (state_q == StSetup) || (state_q == StAccess);
   assign PENABLE     = (state_q == StAccess);
   assign rsp_valid   = (state_q == StResp);
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign PWRITE      = pwrite_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_error   = rsp_error_q;
   assign rsp_timeout = rsp_timeout_q;

endmodule
